// File: rtl/ahb_sif_mem.sv
// Zero-wait-state AHB-Lite slave memory with a 64-bit data bus and a byte-addressed backing array.
// Writes to MAILBOX_ADDR pulse mailbox_write so the environment can capture console output.
module ahb_sif_mem #(
    parameter int          MEM_AW       = 16,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD0580000
) (
    input  logic        core_clk,
    input  logic        reset_l,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hready,
    input  logic [63:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [63:0] hrdata,
    output logic        mailbox_write,
    output logic [63:0] write_data
);

    // Byte storage; never reset so backdoor-loaded contents survive reset.
    logic [7:0] mem [0:(1<<MEM_AW)-1];

    logic        sel;
    logic [31:0] last_addr_q;
    logic [2:0]  last_size_q;
    logic        write_pend_q;
    logic        read_pend_q;
    logic [63:0] hrdata_q;
    logic [63:0] rd_data_d;
    logic [7:0]  wr_be;
    logic [8:0]  lane_lo;
    logic [8:0]  lane_hi;
    logic        same_dw;
    logic        unused_ok;

    assign unused_ok = ^{hburst, hprot, read_pend_q};

    assign sel = hsel & hready & htrans[1];

    // Byte lanes touched by the pending write; lanes past 7 fall off the doubleword.
    always_comb begin
        wr_be   = '0;
        lane_lo = {6'b0, last_addr_q[2:0]};
        lane_hi = lane_lo + (9'd1 << last_size_q);
        for (int k = 0; k < 8; k++) begin
            wr_be[k] = write_pend_q && (9'(k) >= lane_lo) && (9'(k) < lane_hi);
        end
    end

    // A read accepted in the same cycle as a write data phase sees the new bytes.
    assign same_dw = (haddr[MEM_AW-1:3] == last_addr_q[MEM_AW-1:3]);

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < 8; k++) begin
            if (wr_be[k] && same_dw) begin
                rd_data_d[8*k +: 8] = hwdata[8*k +: 8];
            end else begin
                rd_data_d[8*k +: 8] = mem[{haddr[MEM_AW-1:3], 3'(k)}];
            end
        end
    end

    always_ff @(posedge core_clk) begin
        for (int k = 0; k < 8; k++) begin
            if (wr_be[k]) begin
                mem[{last_addr_q[MEM_AW-1:3], 3'(k)}] <= hwdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            last_addr_q  <= '0;
            last_size_q  <= '0;
            write_pend_q <= 1'b0;
            read_pend_q  <= 1'b0;
            hrdata_q     <= '0;
        end else begin
            last_addr_q  <= haddr;
            last_size_q  <= hsize;
            write_pend_q <= sel & hwrite;
            read_pend_q  <= sel & ~hwrite;
            if (sel && !hwrite) begin
                hrdata_q <= rd_data_d;
            end
        end
    end

    assign hreadyout     = 1'b1;
    assign hresp         = 1'b0;
    assign hrdata        = hrdata_q;
    assign mailbox_write = write_pend_q & (last_addr_q == MAILBOX_ADDR);
    assign write_data    = hwdata;

endmodule

// File: tb/tb_ahb_sif_mem.sv
// Directed bench for ahb_sif_mem: a transaction-level memory model drives a per-cycle
// compare process, and literal expectations pin the model at key points.
module tb_ahb_sif_mem;

    localparam logic [31:0] MBX = 32'hD0580000;

    logic        core_clk = 1'b0;
    logic        reset_l;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hready;
    logic [63:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [63:0] hrdata;
    logic        mailbox_write;
    logic [63:0] write_data;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Model state: byte memory plus the one outstanding write data phase.
    logic [7:0]  mm [int unsigned];
    logic        m_pw = 1'b0;
    logic [31:0] m_pa = '0;
    logic [2:0]  m_ps = '0;
    logic [63:0] m_hrdata = '0;

    ahb_sif_mem dut (
        .core_clk(core_clk), .reset_l(reset_l), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata), .mailbox_write(mailbox_write),
        .write_data(write_data)
    );

    always #5 core_clk = ~core_clk;

    function automatic int unsigned dw_base(input logic [31:0] a);
        return int'({16'b0, a[15:3], 3'b000});
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        logic [63:0] d = '0;
        for (int k = 0; k < 8; k++) begin
            int unsigned key = dw_base(a) + k;
            if (mm.exists(key)) d[8*k +: 8] = mm[key];
        end
        return d;
    endfunction

    task automatic model_commit(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            int lane = int'(a[2:0]) + i;
            if (lane < 8) mm[dw_base(a) + lane] = wd[8*lane +: 8];
        end
    endtask

    // What one clock edge does to the memory from the bus's point of view.
    task automatic model_step();
        if (!reset_l) return;
        if (m_pw) model_commit(m_pa, m_ps, hwdata);
        if (hsel && hready && htrans[1]) begin
            if (!hwrite) m_hrdata = model_read(haddr);
            m_pw = hwrite;
            m_pa = haddr;
            m_ps = hsize;
        end else begin
            m_pw = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge core_clk) begin
        if (chk_en) begin
            check("hrdata", hrdata, m_hrdata);
            check("mailbox_write", 64'(mailbox_write), 64'(m_pw && (m_pa == MBX)));
            check("write_data", write_data, hwdata);
            check("hreadyout", 64'(hreadyout), 64'd1);
            check("hresp", 64'(hresp), 64'd0);
        end
    end

    task automatic drive(input logic s, input logic rdy, input logic [1:0] tr, input logic w,
                         input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd);
        hsel = s; hready = rdy; htrans = tr; hwrite = w; haddr = a; hsize = sz; hwdata = wd;
        @(posedge core_clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] prev_wd);
        drive(1'b1, 1'b1, 2'b10, 1'b1, a, sz, prev_wd);
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] prev_wd);
        drive(1'b1, 1'b1, 2'b10, 1'b0, a, 3'd3, prev_wd);
    endtask

    task automatic idle(input logic [63:0] prev_wd);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 3'd0, prev_wd);
    endtask

    initial begin
        reset_l = 1'b0;
        hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0;
        hburst = 0; hprot = 0; hready = 1; hwdata = 0;
        repeat (2) @(posedge core_clk);
        #1;
        chk_en = 1'b1;
        @(posedge core_clk);
        #1;
        reset_l = 1'b1;

        check("reset_hreadyout", 64'(hreadyout), 64'd1);
        check("reset_hresp", 64'(hresp), 64'd0);
        check("reset_hrdata", hrdata, 64'd0);
        check("reset_mailbox", 64'(mailbox_write), 64'd0);

        // IDLE transfer with hsel=1 must not write
        drive(1'b1, 1'b1, 2'b00, 1'b1, 32'h80000008, 3'd3, 64'h0);
        idle(64'hDEADBEEFDEADBEEF);
        rd(32'h80000008, 64'h0);
        check("idle_no_write", hrdata, 64'h0);

        wr(32'h80000008, 3'd3, 64'h0);
        idle(64'h1122334455667788);
        rd(32'h80000008, 64'h0);
        check("dword_rd", hrdata, 64'h1122334455667788);

        wr(32'h8000000A, 3'd0, 64'h0);
        idle(64'hAB << 16);
        rd(32'h80000008, 64'h0);
        check("byte_merge", hrdata, 64'h1122334455AB7788);

        wr(32'h8000000E, 3'd1, 64'h0);
        idle(64'hCDEF << 48);
        rd(32'h80000008, 64'h0);
        check("half_merge", hrdata, 64'hCDEF334455AB7788);

        // Half at lane 7: the second byte would land in lane 8 and is dropped
        wr(32'h8000000F, 3'd1, 64'h0);
        idle(64'h99 << 56);
        rd(32'h80000008, 64'h0);
        check("lane_drop", hrdata, 64'h99EF334455AB7788);

        wr(MBX, 3'd0, 64'h0);
        hwdata = 64'h48;
        #1;
        check("mbx_pulse", 64'(mailbox_write), 64'd1);
        check("mbx_char", 64'(write_data[7:0]), 64'h48);
        idle(64'h48);
        check("mbx_one_cycle", 64'(mailbox_write), 64'd0);

        wr(32'hD0580004, 3'd2, 64'h0);
        hwdata = 64'h21 << 32;
        #1;
        check("mbx_other_addr", 64'(mailbox_write), 64'd0);
        idle(64'h21 << 32);

        drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h80000010, 3'd3, 64'h0);
        idle(64'hFFFFFFFFFFFFFFFF);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h80000010, 3'd3, 64'h0);
        idle(64'hFFFFFFFFFFFFFFFF);
        rd(32'h80000010, 64'h0);
        check("gated_no_write", hrdata, 64'h0);

        // Write immediately followed by a read of the same doubleword
        wr(32'h80000020, 3'd3, 64'h0);
        rd(32'h80000020, 64'hCAFEBABE01234567);
        check("wr_then_rd", hrdata, 64'hCAFEBABE01234567);

        wr(32'h80000028, 3'd2, 64'h0);
        wr(32'h8000002C, 3'd2, 64'h00000000AAAA5555);
        rd(32'h80000028, 64'h12345678_00000000);
        check("b2b_writes", hrdata, 64'h12345678AAAA5555);

        // Reset during the data phase cancels the write and the mailbox pulse
        wr(MBX, 3'd3, 64'h0);
        reset_l = 1'b0;
        m_pw = 1'b0;
        m_hrdata = '0;
        hwdata = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check("rst_mbx_cancel", 64'(mailbox_write), 64'd0);
        idle(64'hFFFFFFFFFFFFFFFF);
        reset_l = 1'b1;
        rd(MBX, 64'h0);
        check("rst_no_write", hrdata, 64'h0000002100000048);
        idle(64'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
